// File: rtl/io64_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : io64_uart_tx
//  Description : Watches the CPU's 16-bit IO64 output word. Each time the word
//                changes it is queued in a small FIFO. Queued words go out on
//                an 8N1 UART line as two frames, high byte first.
//  Revision    : 1.0  initial release
// ============================================================================
module io64_uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [15:0]                  IO64_IN,
    output logic                         TX,
    output logic                         BUSY,
    output logic                         OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]  FIFO_CNT
);

    localparam int                  c_aw         = $clog2(FIFO_DEPTH);
    localparam int                  c_cw         = c_aw + 1;
    localparam logic [c_cw-1:0]     c_full_cnt   = c_cw'(FIFO_DEPTH);
    localparam logic [c_aw-1:0]     c_ptr_one    = c_aw'(1);
    localparam logic [c_cw-1:0]     c_cnt_one    = c_cw'(1);
    localparam logic [15:0]         c_div_last   = 16'(CLK_DIV - 1);
    // Matches the CPU's IO64_OUT after its own reset, so no word is sent at power-up
    localparam logic [15:0]         c_prev_reset = 16'hFC00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO state
    logic [15:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_cw-1:0]  r_cnt;
    logic [15:0]      r_prev;
    logic             r_overflow;

    // Transmitter state
    state_t           r_state;
    logic [15:0]      r_timer;
    logic [2:0]       r_bit_idx;
    logic             r_bsel;
    logic [15:0]      r_shreg;
    logic             r_tx;
    logic             r_busy;

    logic             w_change;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_drop;
    logic             w_bit_end;
    logic [7:0]       w_byte;
    logic             w_data_bit;

    assign w_change   = (IO64_IN != r_prev);
    assign w_full     = (r_cnt == c_full_cnt);
    assign w_pop      = (r_state == S_IDLE) && (r_cnt != '0);
    // A pop on the same edge frees a slot, so a full FIFO still takes the word
    assign w_push_ok  = w_change && (!w_full || w_pop);
    assign w_drop     = w_change && w_full && !w_pop;
    assign w_bit_end  = (r_timer == c_div_last);
    assign w_byte     = r_bsel ? r_shreg[7:0] : r_shreg[15:8];
    assign w_data_bit = w_byte[r_bit_idx];

    // Change detector, FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_prev     <= c_prev_reset;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_prev <= IO64_IN;
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (w_push_ok && !w_pop) begin
                r_cnt <= r_cnt + c_cnt_one;
            end else if (!w_push_ok && w_pop) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge CLK) begin
        if (!RESET && w_push_ok) begin
            r_mem[r_wptr] <= IO64_IN;
        end
    end

    // Frame sequencer; TX is driven from the current state so it lags state by one cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_bsel    <= 1'b0;
            r_shreg   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx    <= 1'b1;
                    r_timer <= '0;
                    if (w_pop) begin
                        r_shreg   <= r_mem[r_rptr];
                        r_bsel    <= 1'b0;
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_bit_end) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_DATA: begin
                    r_tx <= w_data_bit;
                    if (w_bit_end) begin
                        r_timer   <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (!r_bsel) begin
                            r_bsel  <= 1'b1;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered busy flag: a frame is in flight or words are waiting
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE) || (r_cnt != '0);
        end
    end

    assign TX       = r_tx;
    assign BUSY     = r_busy;
    assign OVERFLOW = r_overflow;
    assign FIFO_CNT = r_cnt;

endmodule
`default_nettype wire
